// File: rtl/mux41_pkg.sv
// Shared types and helpers for the round-robin 4:1 mux arbiter.
// Holds the state encoding, port count and the round-robin pick.
package mux41_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int NPORTS = 4;

    // First set request strictly after ptr, wrapping; ptr itself is checked last.
    function automatic logic [1:0] rr_pick(
        input logic [NPORTS-1:0] req,
        input logic [1:0]        ptr
    );
        logic [1:0] idx;
        logic [1:0] res;
        logic       found;
        res   = ptr;
        found = 1'b0;
        for (int i = 1; i <= NPORTS; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux41_4.sv
// Two-level 4:1 mux datapath: s0 picks within each pair, s1 picks the pair.
// Purely combinational; output gating is left to the arbiter.
module mux41_4 #(
    parameter int W = 4
) (
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    input  logic         s0,
    input  logic         s1,
    output logic [W-1:0] y
);

    logic [W-1:0] lo;
    logic [W-1:0] hi;

    assign lo = s0 ? d1 : d0;
    assign hi = s0 ? d3 : d2;
    assign y  = s1 ? hi : lo;

endmodule

// File: rtl/mux41_rr_arbiter.sv
// Round-robin arbiter granting one of four requesters bursts of up to
// BURST_LEN beats through a shared 4:1 mux toward a valid/ready sink.
module mux41_rr_arbiter
    import mux41_pkg::*;
#(
    parameter int W         = 4,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NPORTS-1:0] req,
    input  logic [W-1:0]      d0,
    input  logic [W-1:0]      d1,
    input  logic [W-1:0]      d2,
    input  logic [W-1:0]      d3,
    input  logic              ready,
    output logic [NPORTS-1:0] grant,
    output logic [1:0]        sel,
    output logic              valid,
    output logic [W-1:0]      data_out,
    output logic [NPORTS-1:0] ack,
    output logic              busy
);

    localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

    state_t            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [NPORTS-1:0] grant_q, grant_d;
    logic [1:0]        sel_q, sel_d;
    logic [3:0]        beat_cnt_q, beat_cnt_d;

    logic [1:0]        pick_idx;
    logic              req_cur;
    logic              xfer;
    logic              last_beat;
    logic [W-1:0]      mux_y;

    assign pick_idx  = rr_pick(req, ptr_q);
    assign busy      = (state_q == BUSY);
    assign req_cur   = req[sel_q];
    assign valid     = busy & req_cur;
    assign xfer      = valid & ready;
    assign last_beat = (beat_cnt_q == LAST_BEAT);

    assign grant    = grant_q;
    assign sel      = sel_q;
    assign ack      = grant_q & {NPORTS{xfer}};
    assign data_out = valid ? mux_y : '0;

    mux41_4 #(
        .W (W)
    ) u_mux (
        .d0 (d0),
        .d1 (d1),
        .d2 (d2),
        .d3 (d3),
        .s0 (sel_q[0]),
        .s1 (sel_q[1]),
        .y  (mux_y)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d    = BUSY;
                    grant_d    = NPORTS'(1) << pick_idx;
                    sel_d      = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            BUSY: begin
                // sel is left untouched on release so the mux stays stable.
                if (!req_cur || (xfer && last_beat)) begin
                    state_d    = IDLE;
                    ptr_d      = sel_q;
                    grant_d    = '0;
                    beat_cnt_d = '0;
                end else if (xfer) begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= 2'd3;
            grant_q    <= '0;
            sel_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// Scoreboard bench: two arbiters (bursts of 4 and 1) against a queue-fed
// abstract model of owner / last-served / beats-taken.
module tb_mux41_rr_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   req = '0;
    logic [W-1:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
    logic         ready = 1'b0;

    logic [3:0]   grant_o [2];
    logic [1:0]   sel_o   [2];
    logic         valid_o [2];
    logic [W-1:0] data_o  [2];
    logic [3:0]   ack_o   [2];
    logic         busy_o  [2];

    always #5 clk = ~clk;

    mux41_rr_arbiter #(.W(W), .BURST_LEN(4)) u_dut4 (
        .clk(clk), .reset(reset), .req(req),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .ready(ready),
        .grant(grant_o[0]), .sel(sel_o[0]), .valid(valid_o[0]),
        .data_out(data_o[0]), .ack(ack_o[0]), .busy(busy_o[0])
    );

    mux41_rr_arbiter #(.W(W), .BURST_LEN(1)) u_dut1 (
        .clk(clk), .reset(reset), .req(req),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .ready(ready),
        .grant(grant_o[1]), .sel(sel_o[1]), .valid(valid_o[1]),
        .data_out(data_o[1]), .ack(ack_o[1]), .busy(busy_o[1])
    );

    typedef struct {
        logic [3:0]   grant;
        logic [1:0]   sel;
        logic         busy;
        logic         valid;
        logic [W-1:0] data;
        logic [3:0]   ack;
    } exp_t;

    exp_t sbq [2][$];

    int bl [2] = '{4, 1};
    int owner [2];
    int last  [2];
    int msel  [2];
    int beats [2];

    int n_cmp = 0;
    int n_err = 0;
    bit done = 1'b0;
    bit hold_d = 1'b0;

    task automatic chk(input string nm, input int n,
                       input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s burst=%0d t=%0t got=%h want=%h",
                     nm, bl[n], $time, act, exp);
        end
    endtask

    function automatic logic [W-1:0] dport(input int p);
        case (p)
            0: return d0;
            1: return d1;
            2: return d2;
            default: return d3;
        endcase
    endfunction

    function automatic int rr_next(input logic [3:0] r, input int lst);
        for (int k = 1; k <= 4; k++) begin
            int p;
            p = (lst + k) % 4;
            if (r[p]) return p;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            owner[n] = -1;
            last[n]  = 3;
            msel[n]  = 0;
            beats[n] = 0;
        end
    endtask

    // Advance the model by one clock edge using the inputs held at that edge.
    task automatic model_step();
        if (reset) begin
            model_reset();
            return;
        end
        for (int n = 0; n < 2; n++) begin
            if (owner[n] < 0) begin
                if (req != 0) begin
                    owner[n] = rr_next(req, last[n]);
                    msel[n]  = owner[n];
                    beats[n] = 0;
                end
            end else if (!req[owner[n]]) begin
                last[n]  = owner[n];
                owner[n] = -1;
            end else if (ready) begin
                beats[n]++;
                if (beats[n] == bl[n]) begin
                    last[n]  = owner[n];
                    owner[n] = -1;
                end
            end
        end
    endtask

    function automatic exp_t expect_now(input int n);
        exp_t e;
        e.grant = '0;
        e.sel   = 2'(msel[n]);
        e.busy  = 1'b0;
        e.valid = 1'b0;
        e.data  = '0;
        e.ack   = '0;
        if (owner[n] >= 0) begin
            e.busy  = 1'b1;
            e.grant = 4'(1 << owner[n]);
            e.valid = req[owner[n]];
            if (e.valid) e.data = dport(owner[n]);
            if (e.valid && ready) e.ack = e.grant;
        end
        return e;
    endfunction

    task automatic push_all();
        for (int n = 0; n < 2; n++) sbq[n].push_back(expect_now(n));
    endtask

    task automatic cycle(input logic [3:0] r, input logic rdy, input logic rst);
        @(posedge clk);
        #1;
        model_step();
        req   = r;
        ready = rdy;
        reset = rst;
        if (!hold_d) d2 = W'($urandom);
        d0 = W'($urandom);
        d1 = W'($urandom);
        d3 = W'($urandom);
        push_all();
    endtask

    // Reset between edges: outputs must clear before any further edge.
    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        for (int n = 0; n < 2; n++) begin
            chk("rst_grant", n, 8'(grant_o[n]), 8'h00);
            chk("rst_valid", n, 8'(valid_o[n]), 8'h00);
            chk("rst_data",  n, 8'(data_o[n]),  8'h00);
            chk("rst_ack",   n, 8'(ack_o[n]),   8'h00);
            chk("rst_busy",  n, 8'(busy_o[n]),  8'h00);
            sbq[n].delete();
        end
        model_reset();
        push_all();
    endtask

    initial begin
        exp_t e;
        while (!done) begin
            @(negedge clk);
            for (int n = 0; n < 2; n++) begin
                if (sbq[n].size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_empty burst=%0d t=%0t got=none want=entry",
                             bl[n], $time);
                end else begin
                    e = sbq[n].pop_front();
                    chk("grant", n, 8'(grant_o[n]), 8'(e.grant));
                    chk("sel",   n, 8'(sel_o[n]),   8'(e.sel));
                    chk("busy",  n, 8'(busy_o[n]),  8'(e.busy));
                    chk("valid", n, 8'(valid_o[n]), 8'(e.valid));
                    chk("data",  n, 8'(data_o[n]),  8'(e.data));
                    chk("ack",   n, 8'(ack_o[n]),   8'(e.ack));
                end
            end
        end
    end

    initial begin
        logic [3:0] r;
        bit hit;
        model_reset();
        repeat (2) cycle(4'h0, 1'b0, 1'b1);

        hold_d = 1'b1;
        d2 = 4'hA;
        repeat (14) cycle(4'b0100, 1'b1, 1'b0);
        hold_d = 1'b0;

        repeat (45) cycle(4'hF, 1'b1, 1'b0);

        // Port 1 alone with ready dropped for three cycles mid-burst.
        repeat (3) cycle(4'h0, 1'b1, 1'b0);
        repeat (3) cycle(4'b0010, 1'b1, 1'b0);
        repeat (3) cycle(4'b0010, 1'b0, 1'b0);
        repeat (6) cycle(4'b0010, 1'b1, 1'b0);

        // Port 3 drops after two beats, then port 0 asks.
        repeat (2) cycle(4'h0, 1'b1, 1'b0);
        repeat (3) cycle(4'b1000, 1'b1, 1'b0);
        repeat (2) cycle(4'b0000, 1'b1, 1'b0);
        repeat (6) cycle(4'b1001, 1'b1, 1'b0);

        repeat (30) cycle(4'b0110, 1'($urandom_range(0, 3) != 0), 1'b0);

        r = 4'hF;
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
            cycle(r, 1'($urandom_range(0, 9) < 7), 1'b0);
        end

        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            cycle(4'hF, 1'b1, 1'b0);
            hit = (owner[0] >= 0) && (beats[0] >= 1);
        end
        n_cmp++;
        if (!hit) begin
            n_err++;
            $display("FAIL burst_wait t=%0t got=timeout want=midburst", $time);
        end
        async_reset();
        repeat (2) cycle(4'hF, 1'b1, 1'b1);
        repeat (20) cycle(4'hF, 1'b1, 1'b0);

        for (int i = 0; i < 300; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            cycle(r, 1'($urandom_range(0, 9) < 3), 1'b0);
        end

        @(negedge clk);
        #1;
        done = 1'b1;
        for (int n = 0; n < 2; n++) chk("sb_drain", n, 8'(sbq[n].size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
